// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } statetype_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decode: state (plus ready/zero gating and op legality) to control word.
module mc_outdec
    import mips_ctrl_pkg::*;
(
    input  statetype_t  state_i,
    input  logic        rdy_i,
    input  logic        zero_i,
    input  logic [5:0]  op_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.alusrcb = SRCB_FOUR;
                ctrl_o.irwrite = rdy_i;
                ctrl_o.pcen    = rdy_i;
            end
            DECODE: begin
                ctrl_o.alusrcb = SRCB_IMM_SH2;
                ctrl_o.illegal = ~op_supported(op_i);
            end
            MEMADR, ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
            MEMRD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.pcen    = zero_i;
            end
            ADDIWB: begin
                ctrl_o.regwrite = 1'b1;
            end
            JEX: begin
                ctrl_o.pcsrc = PCSRC_JUMP;
                ctrl_o.pcen  = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: state register, next-state logic and reset gating.
module mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [1:0] aluop,
    output logic       illegal
);

    statetype_t state_q, state_d;
    ctrl_t      ctrl;
    logic       rdy;

    assign rdy = MEM_WAIT ? mem_ready : 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (rdy) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW)      state_d = MEMRD;
                else if (op == OP_SW) state_d = MEMWR;
                else                  state_d = FETCH;
            end
            MEMRD:   if (rdy) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (rdy) state_d = FETCH;
            RTYPEEX: state_d = RTYPEWB;
            RTYPEWB: state_d = FETCH;
            BEQEX:   state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JEX:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    mc_outdec u_outdec (
        .state_i (state_q),
        .rdy_i   (rdy),
        .zero_i  (zero),
        .op_i    (op),
        .ctrl_o  (ctrl)
    );

    // Enables are masked combinationally so an asserted reset silences them in the same cycle.
    assign mem_req  = ctrl.mem_req  & reset;
    assign memwrite = ctrl.memwrite & reset;
    assign irwrite  = ctrl.irwrite  & reset;
    assign pcen     = ctrl.pcen     & reset;
    assign regwrite = ctrl.regwrite & reset;
    assign illegal  = ctrl.illegal  & reset;
    assign iord     = ctrl.iord;
    assign pcsrc    = ctrl.pcsrc;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign aluop    = ctrl.aluop;

endmodule
